// File: rtl/relu_layer_ctrl.sv
// relu_layer_ctrl: sequences one ReLU layer pass, tracking valid tokens beside the fixed-latency datapath
//   clk, reset_n (async active-low); start/num_vec/abort pass control
//   in_valid/in_ready upstream stream; dp_clk_en shared datapath clock enable
//   out_valid/out_ready/out_addr downstream stream; busy, done status
//   RELU_CTRL_PERF_EN adds stall_cnt/bubble_cnt saturating performance counters
module relu_layer_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PIPE_LAT = 6,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dp_clk_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_addr,
  output logic             busy,
  output logic             done
`ifdef RELU_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [PIPE_LAT-1:0] vld;
  logic [CNT_W-1:0] num, issued, retired;
  logic advance, acc, ret;
  if (WIDTH < 1 || PIPE_LAT < 1 || PIPE_LAT > 32) begin : g_bad_param
    $error("relu_layer_ctrl: illegal WIDTH or PIPE_LAT");
  end
  // a held output freezes every stage, operand register included
  assign out_valid = vld[PIPE_LAT-1];
  assign advance   = ~(out_valid & ~out_ready);
  assign dp_clk_en = advance;
  assign in_ready  = (state == RUN) & advance & (issued != num);
  assign acc       = in_valid & in_ready;
  assign ret       = out_valid & out_ready;
  assign out_addr  = retired;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      vld     <= '0;
      num     <= '0;
      issued  <= '0;
      retired <= '0;
    end else if (abort) begin
      state   <= IDLE;
      vld     <= '0;
      issued  <= '0;
      retired <= '0;
    end else begin
      if (advance) vld <= PIPE_LAT'({vld, acc});
      if (acc) issued <= issued + 1'b1;
      if (ret) retired <= retired + 1'b1;
      case (state)
        IDLE: if (start) begin
          num     <= num_vec;
          issued  <= '0;
          retired <= '0;
          state   <= (num_vec == '0) ? DONE : RUN;
        end
        RUN:   if (acc && issued + 1'b1 == num) state <= DRAIN;
        DRAIN: if (ret && retired + 1'b1 == num) state <= DONE;
        DONE: begin
          issued  <= '0;
          retired <= '0;
          state   <= IDLE;
        end
      endcase
    end
`ifdef RELU_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (state == IDLE && start && !abort) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (busy && !advance && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (state == RUN && advance && issued != num && !in_valid && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_relu_layer_ctrl.sv
// tb_relu_layer_ctrl: self-checking bench for relu_layer_ctrl with an address scoreboard
module tb_relu_layer_ctrl;
  localparam int CNT_W = 16;
  localparam int PIPE_LAT = 6;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, in_valid = 0, out_ready = 1;
  logic [CNT_W-1:0] num_vec = '0;
  logic in_ready, dp_clk_en, out_valid, busy, done;
  logic [CNT_W-1:0] out_addr;
`ifdef RELU_CTRL_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  int vectors = 0, errs = 0;
  int exp_q[$];
  int next_addr = 0;
  int sb_e;
  always #5 clk = ~clk;
  relu_layer_ctrl #(.WIDTH(4), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_vec(num_vec), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .dp_clk_en(dp_clk_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .busy(busy), .done(done)
`ifdef RELU_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  // expected addresses enter at acceptance and leave at each downstream handshake
  always @(negedge clk)
    if (reset_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(next_addr);
        next_addr++;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL sb_underflow out_addr=%0d expected no output", out_addr);
        end else begin
          sb_e = exp_q.pop_front();
          if (out_addr !== CNT_W'(sb_e)) begin
            errs++;
            $display("FAIL sb_addr got %0d exp %0d", out_addr, sb_e);
          end
        end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sb_reset();
    exp_q.delete();
    next_addr = 0;
  endtask
  task automatic test_reset();
    reset_n = 0;
    tick();
    tick();
    #1;
    vectors++;
    if ({busy, done, out_valid, in_ready, dp_clk_en} !== 5'b00001) begin
      errs++;
      $display("FAIL reset_flags got %b exp 00001", {busy, done, out_valid, in_ready, dp_clk_en});
    end
    vectors++;
    if (out_addr !== '0) begin
      errs++;
      $display("FAIL reset_addr got %0d exp 0", out_addr);
    end
    reset_n = 1;
  endtask
  task automatic test_basic();
    logic e_ir, e_ov, e_dn, e_bz;
    sb_reset();
    for (int c = 0; c <= 17; c++) begin
      tick();
      start = (c == 0); num_vec = 8; in_valid = 1; out_ready = 1;
      #1;
      if (c > 0) begin
        e_ir = c <= 8; e_ov = c >= 7 && c <= 14; e_dn = c == 15; e_bz = c <= 15;
        vectors++;
        if (in_ready !== e_ir) begin errs++; $display("FAIL basic_in_ready c=%0d got %b exp %b", c, in_ready, e_ir); end
        vectors++;
        if (out_valid !== e_ov) begin errs++; $display("FAIL basic_out_valid c=%0d got %b exp %b", c, out_valid, e_ov); end
        vectors++;
        if (done !== e_dn) begin errs++; $display("FAIL basic_done c=%0d got %b exp %b", c, done, e_dn); end
        vectors++;
        if (busy !== e_bz) begin errs++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, e_bz); end
        if (e_ov) begin
          vectors++;
          if (out_addr !== CNT_W'(c - 7)) begin errs++; $display("FAIL basic_addr c=%0d got %0d exp %0d", c, out_addr, c - 7); end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin errs++; $display("FAIL basic_leftover got %0d exp 0", exp_q.size()); end
  endtask
  task automatic test_stall();
    logic e_en, e_ir, e_ov, e_dn;
    sb_reset();
    for (int c = 0; c <= 16; c++) begin
      tick();
      start = (c == 0); num_vec = 4; in_valid = 1; out_ready = !(c >= 7 && c <= 9);
      #1;
      if (c > 0) begin
        e_en = !(c >= 7 && c <= 9); e_ir = c <= 4; e_ov = c >= 7 && c <= 13; e_dn = c == 14;
        vectors++;
        if (dp_clk_en !== e_en) begin errs++; $display("FAIL stall_clk_en c=%0d got %b exp %b", c, dp_clk_en, e_en); end
        vectors++;
        if (in_ready !== e_ir) begin errs++; $display("FAIL stall_in_ready c=%0d got %b exp %b", c, in_ready, e_ir); end
        vectors++;
        if (out_valid !== e_ov) begin errs++; $display("FAIL stall_out_valid c=%0d got %b exp %b", c, out_valid, e_ov); end
        vectors++;
        if (done !== e_dn) begin errs++; $display("FAIL stall_done c=%0d got %b exp %b", c, done, e_dn); end
        if (e_ov) begin
          vectors++;
          if (out_addr !== CNT_W'(c <= 10 ? 0 : c - 10)) begin errs++; $display("FAIL stall_addr c=%0d got %0d exp %0d", c, out_addr, c <= 10 ? 0 : c - 10); end
        end
      end
    end
    out_ready = 1;
`ifdef RELU_CTRL_PERF_EN
    vectors++;
    if (stall_cnt !== 32'd3) begin errs++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
`endif
    vectors++;
    if (exp_q.size() != 0) begin errs++; $display("FAIL stall_leftover got %0d exp 0", exp_q.size()); end
  endtask
  task automatic test_gaps();
    logic e_ir, e_ov;
    int n_acc = 0, n_done = 0;
    sb_reset();
    for (int c = 0; c <= 18; c++) begin
      tick();
      start = (c == 0); num_vec = 5; in_valid = c >= 1 && (c % 2 == 1); out_ready = 1;
      #1;
      if (in_valid && in_ready) n_acc++;
      if (done) n_done++;
      if (c > 0) begin
        e_ir = c <= 9; e_ov = c >= 7 && c <= 15 && (c % 2 == 1);
        vectors++;
        if (in_ready !== e_ir) begin errs++; $display("FAIL gaps_in_ready c=%0d got %b exp %b", c, in_ready, e_ir); end
        vectors++;
        if (out_valid !== e_ov) begin errs++; $display("FAIL gaps_out_valid c=%0d got %b exp %b", c, out_valid, e_ov); end
        if (e_ov) begin
          vectors++;
          if (out_addr !== CNT_W'((c - 7) / 2)) begin errs++; $display("FAIL gaps_addr c=%0d got %0d exp %0d", c, out_addr, (c - 7) / 2); end
        end
      end
    end
    in_valid = 0;
    vectors++;
    if (n_acc != 5) begin errs++; $display("FAIL gaps_accepts got %0d exp 5", n_acc); end
    vectors++;
    if (n_done != 1) begin errs++; $display("FAIL gaps_done_count got %0d exp 1", n_done); end
  endtask
  task automatic test_zero();
    sb_reset();
    for (int c = 0; c <= 4; c++) begin
      tick();
      start = (c == 0); num_vec = 0; in_valid = 1;
      #1;
      if (c > 0) begin
        vectors++;
        if (done !== (c == 1)) begin errs++; $display("FAIL zero_done c=%0d got %b exp %b", c, done, c == 1); end
        vectors++;
        if (busy !== (c == 1)) begin errs++; $display("FAIL zero_busy c=%0d got %b exp %b", c, busy, c == 1); end
        vectors++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL zero_in_ready c=%0d got %b exp 0", c, in_ready); end
        vectors++;
        if (dp_clk_en !== 1'b1) begin errs++; $display("FAIL zero_clk_en c=%0d got %b exp 1", c, dp_clk_en); end
      end
    end
    in_valid = 0;
  endtask
  task automatic test_abort();
    int n_acc = 0;
    logic e_ov;
    sb_reset();
    for (int c = 0; c <= 12; c++) begin
      tick();
      start = (c == 0); num_vec = 10; in_valid = c <= 4; abort = (c == 8);
      #1;
      if (in_valid && in_ready) n_acc++;
      if (c == 8) begin
        vectors++;
        if (out_valid !== 1'b1) begin errs++; $display("FAIL abort_inflight got %b exp 1", out_valid); end
      end
      if (c >= 9) begin
        vectors++;
        if ({busy, out_valid, done} !== 3'b000) begin errs++; $display("FAIL abort_flush c=%0d got %b exp 000", c, {busy, out_valid, done}); end
      end else if (c > 0) begin
        vectors++;
        if (done !== 1'b0) begin errs++; $display("FAIL abort_early_done c=%0d got %b exp 0", c, done); end
      end
      if (c == 9) sb_reset();
    end
    abort = 0;
    vectors++;
    if (n_acc != 4) begin errs++; $display("FAIL abort_accepts got %0d exp 4", n_acc); end
    sb_reset();
    for (int c = 0; c <= 12; c++) begin
      tick();
      start = (c == 0); num_vec = 3; in_valid = 1;
      #1;
      if (c > 0) begin
        e_ov = c >= 7 && c <= 9;
        vectors++;
        if (in_ready !== (c <= 3)) begin errs++; $display("FAIL restart_in_ready c=%0d got %b exp %b", c, in_ready, c <= 3); end
        vectors++;
        if (out_valid !== e_ov) begin errs++; $display("FAIL restart_out_valid c=%0d got %b exp %b", c, out_valid, e_ov); end
        vectors++;
        if (done !== (c == 10)) begin errs++; $display("FAIL restart_done c=%0d got %b exp %b", c, done, c == 10); end
        if (e_ov) begin
          vectors++;
          if (out_addr !== CNT_W'(c - 7)) begin errs++; $display("FAIL restart_addr c=%0d got %0d exp %0d", c, out_addr, c - 7); end
        end
      end
    end
    in_valid = 0;
  endtask
  task automatic test_async_reset();
    sb_reset();
    for (int c = 0; c <= 8; c++) begin
      tick();
      start = (c == 0); num_vec = 4; in_valid = 1;
      #1;
    end
    vectors++;
    if ({busy, in_ready, out_valid} !== 3'b101 || out_addr !== CNT_W'(1)) begin
      errs++;
      $display("FAIL drain_state got busy/ir/ov=%b addr=%0d exp 101 addr=1", {busy, in_ready, out_valid}, out_addr);
    end
    #1;
    reset_n = 0;
    #1;
    vectors++;
    if ({busy, done, out_valid, in_ready, dp_clk_en} !== 5'b00001) begin
      errs++;
      $display("FAIL async_reset_flags got %b exp 00001", {busy, done, out_valid, in_ready, dp_clk_en});
    end
    vectors++;
    if (out_addr !== '0) begin errs++; $display("FAIL async_reset_addr got %0d exp 0", out_addr); end
`ifdef RELU_CTRL_PERF_EN
    vectors++;
    if (stall_cnt !== 32'd0) begin errs++; $display("FAIL async_reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
    in_valid = 0;
    sb_reset();
    #2;
    reset_n = 1;
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0) begin errs++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_zero();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
